// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I/RV32E core: opcodes, ALU
// control, FSM states, immediate formats and the ALU itself.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_EXEC_I  = 4'd3,
        ST_MEM_ADR = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_MEM_WB  = 4'd6,
        ST_MEM_WR  = 4'd7,
        ST_ALU_WB  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10,
        ST_TRAP    = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_type_e;

    // Shared 32-bit ALU; all arithmetic wraps, slt compares signed.
    function automatic logic [31:0] alu_fn(input alu_op_e op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] res;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = {31'd0, ($signed(a) < $signed(b))};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// x0 reads as zero and ignores writes; indices beyond NUM_REGS read zero.
module mc_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

    logic [31:0] regs_r [NUM_REGS];

    function automatic logic idx_valid(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NUM_REGS_W);
    endfunction

    // Combinational read ports with x0 / out-of-range returning zero.
    always_comb begin
        rdata1 = 32'd0;
        rdata2 = 32'd0;
        if (idx_valid(raddr1)) begin
            rdata1 = regs_r[raddr1[IDX_W-1:0]];
        end else begin
            rdata1 = 32'd0;
        end
        if (idx_valid(raddr2)) begin
            rdata2 = regs_r[raddr2[IDX_W-1:0]];
        end else begin
            rdata2 = 32'd0;
        end
    end

    // Synchronous write; reset clears the whole file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (we && idx_valid(waddr)) begin
            regs_r[waddr[IDX_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/multi_cycle_riscv_core.sv
// Multi-cycle RV32I/RV32E subset core with a single shared req/ready memory
// port, a trap/halt state for illegal or misaligned work, and an instret count.
module multi_cycle_riscv_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic             halted,
    output logic [31:0]      trap_pc,
    output logic [CNT_W-1:0] instret
);

    localparam bit             IS_RV32E = (NUM_REGS == 16);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    alu_op_e          alu_op_r;
    logic [31:0]      pc_r, old_pc_r, ir_r, a_r, b_r, imm_r;
    logic [31:0]      alu_out_r, mdr_r, trap_pc_r;
    logic [CNT_W-1:0] instret_r;

    logic [6:0]  opcode_s, funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [31:0] rf_rdata1_s, rf_rdata2_s, imm_ext_s;
    logic [31:0] ea_s, br_tgt_s, jal_tgt_s, rf_wdata_s;
    logic        use_rd_s, use_rs1_s, use_rs2_s, reg_bad_s, rf_we_s;
    imm_type_e   imm_type_s;
    alu_op_e     alu_op_dec_s;
    state_e      dispatch_s, dec_next_s;

    assign opcode_s  = ir_r[6:0];
    assign rd_s      = ir_r[11:7];
    assign funct3_s  = ir_r[14:12];
    assign rs1_s     = ir_r[19:15];
    assign rs2_s     = ir_r[24:20];
    assign funct7_s  = ir_r[31:25];
    assign ea_s      = a_r + imm_r;
    assign br_tgt_s  = old_pc_r + imm_r;
    assign jal_tgt_s = old_pc_r + imm_r;

    // Instruction decode: dispatch state, ALU control, immediate format, used registers.
    always_comb begin
        dispatch_s   = ST_TRAP;
        alu_op_dec_s = ALU_ADD;
        imm_type_s   = IMM_I;
        use_rd_s     = 1'b0;
        use_rs1_s    = 1'b0;
        use_rs2_s    = 1'b0;
        case (opcode_s)
            OP_R: begin
                use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                dispatch_s = ST_EXEC_R;
                case ({funct7_s, funct3_s})
                    {7'h00, 3'b000}: alu_op_dec_s = ALU_ADD;
                    {7'h20, 3'b000}: alu_op_dec_s = ALU_SUB;
                    {7'h00, 3'b111}: alu_op_dec_s = ALU_AND;
                    {7'h00, 3'b110}: alu_op_dec_s = ALU_OR;
                    {7'h00, 3'b010}: alu_op_dec_s = ALU_SLT;
                    default:         dispatch_s   = ST_TRAP;
                endcase
            end
            OP_I: begin
                use_rd_s = 1'b1; use_rs1_s = 1'b1;
                dispatch_s = ST_EXEC_I;
                case (funct3_s)
                    3'b000:  alu_op_dec_s = ALU_ADD;
                    3'b111:  alu_op_dec_s = ALU_AND;
                    3'b110:  alu_op_dec_s = ALU_OR;
                    3'b010:  alu_op_dec_s = ALU_SLT;
                    default: dispatch_s   = ST_TRAP;
                endcase
            end
            OP_LW: begin
                use_rd_s = 1'b1; use_rs1_s = 1'b1;
                dispatch_s = (funct3_s == 3'b010) ? ST_MEM_ADR : ST_TRAP;
            end
            OP_SW: begin
                use_rs1_s = 1'b1; use_rs2_s = 1'b1; imm_type_s = IMM_S;
                dispatch_s = (funct3_s == 3'b010) ? ST_MEM_ADR : ST_TRAP;
            end
            OP_BEQ: begin
                use_rs1_s = 1'b1; use_rs2_s = 1'b1; imm_type_s = IMM_B;
                dispatch_s = (funct3_s == 3'b000) ? ST_BRANCH : ST_TRAP;
            end
            OP_JAL: begin
                use_rd_s = 1'b1; imm_type_s = IMM_J;
                dispatch_s = ST_JUMP;
            end
            default: dispatch_s = ST_TRAP;
        endcase
    end

    // RV32E only has x0..x15; any used field naming x16..x31 is illegal.
    assign reg_bad_s  = IS_RV32E && ((use_rd_s && rd_s[4]) || (use_rs1_s && rs1_s[4]) ||
                                     (use_rs2_s && rs2_s[4]));
    assign dec_next_s = reg_bad_s ? ST_TRAP : dispatch_s;

    // Sign-extend the immediate for the decoded format.
    always_comb begin
        imm_ext_s = 32'd0;
        case (imm_type_s)
            IMM_I:   imm_ext_s = {{20{ir_r[31]}}, ir_r[31:20]};
            IMM_S:   imm_ext_s = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
            IMM_B:   imm_ext_s = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
            IMM_J:   imm_ext_s = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
            default: imm_ext_s = 32'd0;
        endcase
    end

    // Register write-back select; a misaligned jal writes nothing.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_wdata_s = 32'd0;
        case (state_r)
            ST_ALU_WB: begin rf_we_s = 1'b1; rf_wdata_s = alu_out_r; end
            ST_MEM_WB: begin rf_we_s = 1'b1; rf_wdata_s = mdr_r; end
            ST_JUMP: begin
                rf_wdata_s = old_pc_r + 32'd4;
                if (jal_tgt_s[1:0] == 2'b00) begin
                    rf_we_s = 1'b1;
                end else begin
                    rf_we_s = 1'b0;
                end
            end
            default: rf_we_s = 1'b0;
        endcase
    end

    mc_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1_s),
        .raddr2 (rs2_s),
        .rdata1 (rf_rdata1_s),
        .rdata2 (rf_rdata2_s),
        .we     (rf_we_s),
        .waddr  (rd_s),
        .wdata  (rf_wdata_s)
    );

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            old_pc_r  <= 32'd0;
            ir_r      <= 32'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            imm_r     <= 32'd0;
            alu_out_r <= 32'd0;
            mdr_r     <= 32'd0;
            trap_pc_r <= 32'd0;
            instret_r <= {CNT_W{1'b0}};
            alu_op_r  <= ALU_ADD;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir_r     <= mem_rdata;
                        old_pc_r <= pc_r;
                        pc_r     <= pc_r + 32'd4;
                        state_r  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_r      <= rf_rdata1_s;
                    b_r      <= rf_rdata2_s;
                    imm_r    <= imm_ext_s;
                    alu_op_r <= alu_op_dec_s;
                    state_r  <= dec_next_s;
                    if (dec_next_s == ST_TRAP) begin
                        trap_pc_r <= old_pc_r;
                    end
                end
                ST_EXEC_R: begin
                    alu_out_r <= alu_fn(alu_op_r, a_r, b_r);
                    state_r   <= ST_ALU_WB;
                end
                ST_EXEC_I: begin
                    alu_out_r <= alu_fn(alu_op_r, a_r, imm_r);
                    state_r   <= ST_ALU_WB;
                end
                ST_ALU_WB, ST_MEM_WB: begin
                    instret_r <= instret_r + CNT_ONE;
                    state_r   <= ST_FETCH;
                end
                ST_MEM_ADR: begin
                    alu_out_r <= ea_s;
                    if (ea_s[1:0] != 2'b00) begin
                        trap_pc_r <= old_pc_r;
                        state_r   <= ST_TRAP;
                    end else if (opcode_s == OP_LW) begin
                        state_r <= ST_MEM_RD;
                    end else begin
                        state_r <= ST_MEM_WR;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        mdr_r   <= mem_rdata;
                        state_r <= ST_MEM_WB;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ready) begin
                        instret_r <= instret_r + CNT_ONE;
                        state_r   <= ST_FETCH;
                    end
                end
                ST_BRANCH: begin
                    if ((a_r == b_r) && (br_tgt_s[1:0] != 2'b00)) begin
                        trap_pc_r <= old_pc_r;
                        state_r   <= ST_TRAP;
                    end else begin
                        if (a_r == b_r) begin
                            pc_r <= br_tgt_s;
                        end
                        instret_r <= instret_r + CNT_ONE;
                        state_r   <= ST_FETCH;
                    end
                end
                ST_JUMP: begin
                    if (jal_tgt_s[1:0] != 2'b00) begin
                        trap_pc_r <= old_pc_r;
                        state_r   <= ST_TRAP;
                    end else begin
                        pc_r      <= jal_tgt_s;
                        instret_r <= instret_r + CNT_ONE;
                        state_r   <= ST_FETCH;
                    end
                end
                ST_TRAP: state_r <= ST_TRAP;
                default: begin
                    trap_pc_r <= old_pc_r;
                    state_r   <= ST_TRAP;
                end
            endcase
        end
    end

    // Memory port decode from state; no request is issued while in reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {alu_out_r[31:2], 2'b00};
        mem_wdata = b_r;
        if (state_r == ST_FETCH) begin
            mem_addr = {pc_r[31:2], 2'b00};
        end else begin
            mem_addr = {alu_out_r[31:2], 2'b00};
        end
        if (!rst && ((state_r == ST_FETCH) || (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR))) begin
            mem_req = 1'b1;
            mem_we  = (state_r == ST_MEM_WR);
        end else begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    assign halted  = (state_r == ST_TRAP);
    assign trap_pc = trap_pc_r;
    assign instret = instret_r;

endmodule

// File: tb/tb_multi_cycle_riscv_core.sv
// Directed self-checking bench for multi_cycle_riscv_core (RV32I and RV32E builds).
module tb_multi_cycle_riscv_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel_b;
    logic        req_a, we_a, halted_a, req_b, we_b, halted_b;
    logic [31:0] addr_a, wdata_a, trap_pc_a, instret_a;
    logic [31:0] addr_b, wdata_b, trap_pc_b, instret_b;
    logic        req_s, we_s, ready_s, ready_a, ready_b;
    logic [31:0] addr_s, wdata_s, rdata_s;

    logic [31:0] mem [64];
    logic        clr, ld_en;
    logic [5:0]  ld_a;
    logic [31:0] ld_d;
    int          wait_cfg, wcnt, wr_cnt;
    logic [31:0] last_wa, last_wd;
    int          n_cmp, n_bad;

    multi_cycle_riscv_core #(.RESET_PC(32'h0), .NUM_REGS(32), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(rdata_s), .mem_ready(ready_a),
        .halted(halted_a), .trap_pc(trap_pc_a), .instret(instret_a));

    multi_cycle_riscv_core #(.RESET_PC(32'h0), .NUM_REGS(16), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(rdata_s), .mem_ready(ready_b),
        .halted(halted_b), .trap_pc(trap_pc_b), .instret(instret_b));

    assign req_s   = sel_b ? req_b : req_a;
    assign we_s    = sel_b ? we_b : we_a;
    assign addr_s  = sel_b ? addr_b : addr_a;
    assign wdata_s = sel_b ? wdata_b : wdata_a;
    assign ready_s = (wcnt >= wait_cfg);
    assign ready_a = sel_b ? 1'b0 : ready_s;
    assign ready_b = sel_b ? ready_s : 1'b0;
    assign rdata_s = mem[addr_s[7:2]];

    // Memory model: program loading, wait-state counter and store log.
    always @(posedge clk) begin
        if (!req_s || ready_s) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            wr_cnt <= 0;
        end else if (ld_en) begin
            mem[ld_a] <= ld_d;
        end else if (req_s && ready_s && we_s) begin
            mem[addr_s[7:2]] <= wdata_s;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= addr_s;
            last_wd <= wdata_s;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        clr = 1'b1; @(negedge clk); clr = 1'b0;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_a = a[7:2]; ld_d = d; @(negedge clk); ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        clear_mem();
        poke(32'h00, 32'h00500093);   // addi x1,x0,5
        poke(32'h04, 32'h00700113);   // addi x2,x0,7
        poke(32'h08, 32'h002081B3);   // add  x3,x1,x2
        poke(32'h0C, 32'h00302423);   // sw   x3,8(x0)
        poke(32'h10, 32'h00802203);   // lw   x4,8(x0)
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", req_a); end
        n_cmp++; if (halted_a !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted_a); end
        n_cmp++; if (instret_a !== 32'd0) begin n_bad++; $display("FAIL rst_instret: got %0d want 0", instret_a); end
        n_cmp++; if (trap_pc_a !== 32'd0) begin n_bad++; $display("FAIL rst_trap_pc: got %h want 0", trap_pc_a); end
        rst_a = 1'b0; #1;
        n_cmp++; if (req_a !== 1'b1 || we_a !== 1'b0 || addr_a !== 32'h0)
            begin n_bad++; $display("FAIL first_fetch: got req=%b we=%b addr=%h want 1 0 0", req_a, we_a, addr_a); end
    endtask

    task automatic test_alu_basic();
        step(11);
        n_cmp++; if (instret_a !== 32'd2) begin n_bad++; $display("FAIL alu_lat11: got %0d want 2", instret_a); end
        step(1);
        n_cmp++; if (instret_a !== 32'd3) begin n_bad++; $display("FAIL alu_lat12: got %0d want 3", instret_a); end
        n_cmp++; if (dut_a.u_regfile.regs_r[3] !== 32'd12) begin n_bad++; $display("FAIL add_x3: got %0d want 12", dut_a.u_regfile.regs_r[3]); end
        n_cmp++; if (addr_a !== 32'hC || req_a !== 1'b1) begin n_bad++; $display("FAIL fetch_after_add: got %h want c", addr_a); end
    endtask

    task automatic test_mem_wait();
        wait_cfg = 2;
        step(7);
        n_cmp++; if (req_a !== 1'b1 || we_a !== 1'b1 || addr_a !== 32'h8 || wdata_a !== 32'd12)
            begin n_bad++; $display("FAIL sw_hold: got req=%b we=%b addr=%h data=%h want 1 1 8 c", req_a, we_a, addr_a, wdata_a); end
        n_cmp++; if (instret_a !== 32'd3) begin n_bad++; $display("FAIL sw_lat7: got %0d want 3", instret_a); end
        step(1);
        n_cmp++; if (instret_a !== 32'd4) begin n_bad++; $display("FAIL sw_lat8: got %0d want 4", instret_a); end
        n_cmp++; if (wr_cnt !== 1 || last_wa !== 32'h8 || last_wd !== 32'd12)
            begin n_bad++; $display("FAIL sw_write: got n=%0d addr=%h data=%h want 1 8 c", wr_cnt, last_wa, last_wd); end
        step(8);
        n_cmp++; if (instret_a !== 32'd4) begin n_bad++; $display("FAIL lw_lat8: got %0d want 4", instret_a); end
        step(1);
        n_cmp++; if (instret_a !== 32'd5) begin n_bad++; $display("FAIL lw_lat9: got %0d want 5", instret_a); end
        n_cmp++; if (dut_a.u_regfile.regs_r[4] !== 32'd12) begin n_bad++; $display("FAIL lw_x4: got %0d want 12", dut_a.u_regfile.regs_r[4]); end
        wait_cfg = 0;
    endtask

    task automatic test_alu_ops();
        rst_a = 1'b1;
        clear_mem();
        poke(32'h00, 32'hFFD00093);   // addi x1,x0,-3
        poke(32'h04, 32'h00500113);   // addi x2,x0,5
        poke(32'h08, 32'h0020A1B3);   // slt  x3,x1,x2
        poke(32'h0C, 32'h40110233);   // sub  x4,x2,x1
        poke(32'h10, 32'h0020F2B3);   // and  x5,x1,x2
        poke(32'h14, 32'h0020E333);   // or   x6,x1,x2
        poke(32'h18, 32'hFFF12393);   // slti x7,x2,-1
        poke(32'h1C, 32'h0F00F413);   // andi x8,x1,0xF0
        poke(32'h20, 32'hFF016493);   // ori  x9,x2,-16
        poke(32'h24, 32'h022081B3);   // mul (not supported)
        rst_a = 1'b0;
        step(36);
        n_cmp++; if (instret_a !== 32'd9) begin n_bad++; $display("FAIL ops_instret: got %0d want 9", instret_a); end
        n_cmp++; if (dut_a.u_regfile.regs_r[3] !== 32'd1) begin n_bad++; $display("FAIL slt: got %h want 1", dut_a.u_regfile.regs_r[3]); end
        n_cmp++; if (dut_a.u_regfile.regs_r[4] !== 32'd8) begin n_bad++; $display("FAIL sub: got %h want 8", dut_a.u_regfile.regs_r[4]); end
        n_cmp++; if (dut_a.u_regfile.regs_r[5] !== 32'd5) begin n_bad++; $display("FAIL and: got %h want 5", dut_a.u_regfile.regs_r[5]); end
        n_cmp++; if (dut_a.u_regfile.regs_r[6] !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL or: got %h want fffffffd", dut_a.u_regfile.regs_r[6]); end
        n_cmp++; if (dut_a.u_regfile.regs_r[7] !== 32'd0) begin n_bad++; $display("FAIL slti: got %h want 0", dut_a.u_regfile.regs_r[7]); end
        n_cmp++; if (dut_a.u_regfile.regs_r[8] !== 32'hF0) begin n_bad++; $display("FAIL andi: got %h want f0", dut_a.u_regfile.regs_r[8]); end
        n_cmp++; if (dut_a.u_regfile.regs_r[9] !== 32'hFFFFFFF5) begin n_bad++; $display("FAIL ori: got %h want fffffff5", dut_a.u_regfile.regs_r[9]); end
        step(2);
        n_cmp++; if (halted_a !== 1'b1 || trap_pc_a !== 32'h24 || instret_a !== 32'd9)
            begin n_bad++; $display("FAIL illegal_funct7: got h=%b pc=%h n=%0d want 1 24 9", halted_a, trap_pc_a, instret_a); end
    endtask

    task automatic test_branch_jump_trap();
        rst_a = 1'b1;
        clear_mem();
        poke(32'h00, 32'h00500093);   // addi x1,x0,5
        poke(32'h04, 32'h00700113);   // addi x2,x0,7
        poke(32'h08, 32'h00900013);   // addi x0,x0,9
        poke(32'h0C, 32'h00000333);   // add  x6,x0,x0
        poke(32'h10, 32'h00108463);   // beq  x1,x1,+8
        poke(32'h18, 32'h00208463);   // beq  x1,x2,+8
        poke(32'h1C, 32'h00000013);   // nop
        poke(32'h20, 32'h010002EF);   // jal  x5,+16
        poke(32'h30, 32'h0100006F);   // jal  x0,+16
        poke(32'h40, 32'hFFFFFFFF);   // illegal
        rst_a = 1'b0;
        step(16);
        n_cmp++; if (addr_a !== 32'h10 || instret_a !== 32'd4) begin n_bad++; $display("FAIL pre_beq: got %h/%0d want 10/4", addr_a, instret_a); end
        n_cmp++; if (dut_a.u_regfile.regs_r[6] !== 32'd0) begin n_bad++; $display("FAIL x0_write: got x6=%h want 0", dut_a.u_regfile.regs_r[6]); end
        step(3);
        n_cmp++; if (addr_a !== 32'h18 || instret_a !== 32'd5) begin n_bad++; $display("FAIL beq_taken: got %h/%0d want 18/5", addr_a, instret_a); end
        step(3);
        n_cmp++; if (addr_a !== 32'h1C || instret_a !== 32'd6) begin n_bad++; $display("FAIL beq_not_taken: got %h/%0d want 1c/6", addr_a, instret_a); end
        step(4);
        n_cmp++; if (addr_a !== 32'h20) begin n_bad++; $display("FAIL nop_pc: got %h want 20", addr_a); end
        step(3);
        n_cmp++; if (addr_a !== 32'h30 || instret_a !== 32'd8) begin n_bad++; $display("FAIL jal_target: got %h/%0d want 30/8", addr_a, instret_a); end
        n_cmp++; if (dut_a.u_regfile.regs_r[5] !== 32'h24) begin n_bad++; $display("FAIL jal_link: got %h want 24", dut_a.u_regfile.regs_r[5]); end
        step(5);
        n_cmp++; if (halted_a !== 1'b1 || trap_pc_a !== 32'h40 || req_a !== 1'b0)
            begin n_bad++; $display("FAIL trap_enter: got h=%b pc=%h req=%b want 1 40 0", halted_a, trap_pc_a, req_a); end
        step(5);
        n_cmp++; if (halted_a !== 1'b1 || req_a !== 1'b0 || instret_a !== 32'd9)
            begin n_bad++; $display("FAIL trap_hold: got h=%b req=%b n=%0d want 1 0 9", halted_a, req_a, instret_a); end
        rst_a = 1'b1;
        step(1);
        n_cmp++; if (req_a !== 1'b0 || halted_a !== 1'b0 || instret_a !== 32'd0 || trap_pc_a !== 32'd0)
            begin n_bad++; $display("FAIL trap_reset: got req=%b h=%b n=%0d pc=%h want 0 0 0 0", req_a, halted_a, instret_a, trap_pc_a); end
        rst_a = 1'b0; #1;
        n_cmp++; if (req_a !== 1'b1 || addr_a !== 32'h0) begin n_bad++; $display("FAIL refetch: got req=%b addr=%h want 1 0", req_a, addr_a); end
    endtask

    task automatic test_misaligned();
        rst_a = 1'b1;
        clear_mem();
        poke(32'h00, 32'h00202083);   // lw x1,2(x0)
        rst_a = 1'b0;
        step(1);
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL lw_mis_decode_req: got %b want 0", req_a); end
        step(1);
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL lw_mis_adr_req: got %b want 0", req_a); end
        step(1);
        n_cmp++; if (halted_a !== 1'b1 || trap_pc_a !== 32'h0 || instret_a !== 32'd0 || req_a !== 1'b0)
            begin n_bad++; $display("FAIL lw_misaligned: got h=%b pc=%h n=%0d want 1 0 0", halted_a, trap_pc_a, instret_a); end
        rst_a = 1'b1;
        poke(32'h00, 32'h002002EF);   // jal x5,+2
        rst_a = 1'b0;
        step(3);
        n_cmp++; if (halted_a !== 1'b1 || dut_a.u_regfile.regs_r[5] !== 32'd0)
            begin n_bad++; $display("FAIL jal_misaligned: got h=%b x5=%h want 1 0", halted_a, dut_a.u_regfile.regs_r[5]); end
        rst_a = 1'b1;
        poke(32'h00, 32'h00000163);   // beq x0,x0,+2
        rst_a = 1'b0;
        step(3);
        n_cmp++; if (halted_a !== 1'b1 || instret_a !== 32'd0) begin n_bad++; $display("FAIL beq_misaligned: got h=%b n=%0d want 1 0", halted_a, instret_a); end
    endtask

    task automatic test_rv32e();
        rst_a = 1'b1;
        sel_b = 1'b1;
        clear_mem();
        poke(32'h00, 32'h00500093);   // addi x1,x0,5
        poke(32'h04, 32'h002088B3);   // add  x17,x1,x2
        rst_b = 1'b0;
        step(4);
        n_cmp++; if (instret_b !== 32'd1 || dut_b.u_regfile.regs_r[1] !== 32'd5)
            begin n_bad++; $display("FAIL e_addi: got n=%0d x1=%h want 1 5", instret_b, dut_b.u_regfile.regs_r[1]); end
        step(2);
        n_cmp++; if (halted_b !== 1'b1 || trap_pc_b !== 32'h4 || instret_b !== 32'd1)
            begin n_bad++; $display("FAIL e_x17_trap: got h=%b pc=%h n=%0d want 1 4 1", halted_b, trap_pc_b, instret_b); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0;
        clr = 1'b0; ld_en = 1'b0; ld_a = 6'd0; ld_d = 32'd0;
        wait_cfg = 0; wcnt = 0; wr_cnt = 0; last_wa = 32'd0; last_wd = 32'd0;
        @(negedge clk);
        test_reset();
        test_alu_basic();
        test_mem_wait();
        test_alu_ops();
        test_branch_jump_trap();
        test_misaligned();
        test_rv32e();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
